ncl_wavefront_sequencer: RTL

Clocked sequencer that drives one NCL combinational stage built from threshold gates (th12 and relatives) through complete DATA/NULL wavefront cycles. It encodes a binary operand onto dual-rail inputs, waits on the stage's completion signal `ko`, checks and decodes the dual-rail result, then returns the stage to NULL. It sits between the synchronous test/control logic and any NCL gate network in functional simulation. It provides timeout and illegal-code detection.

---
 rtl/ncl_wavefront_sequencer_if.sv | 28 ++
 rtl/ncl_wavefront_sequencer.sv | 63 ++++++
 2 files changed

// File: rtl/ncl_wavefront_sequencer_if.sv
// ncl_wavefront_sequencer_if: bundle between sync control, the sequencer and one NCL stage
// start/din/ready : synchronous request side
// rail_t/rail_f   : dual-rail operand to the stage; ko/res_t/res_f back from it
// dout/done/err   : decoded result, completion pulse, sticky error
interface ncl_wavefront_sequencer_if #(
  parameter int W = 2,
  parameter int R = 1
);
  logic         start;
  logic [W-1:0] din;
  logic         ready;
  logic [W-1:0] rail_t;
  logic [W-1:0] rail_f;
  logic         ko;
  logic [R-1:0] res_t;
  logic [R-1:0] res_f;
  logic [R-1:0] dout;
  logic         done;
  logic         err;
  modport master (
    output start, din, ko, res_t, res_f,
    input  ready, rail_t, rail_f, dout, done, err
  );
  modport slave (
    input  start, din, ko, res_t, res_f,
    output ready, rail_t, rail_f, dout, done, err
  );
endinterface

// File: rtl/ncl_wavefront_sequencer.sv
// ncl_wavefront_sequencer: drives one NCL stage through DATA/NULL wavefronts
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of ncl_wavefront_sequencer_if (start/din/ready, rails, ko, res, dout/done/err)
module ncl_wavefront_sequencer #(
  parameter int W       = 2,
  parameter int R       = 1,
  parameter int TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      rst,
  ncl_wavefront_sequencer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA_WAIT, NULL_WAIT, ERROR} state_t;
  state_t        state, state_n;
  logic          sync1, ko_s;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rail_t, rail_f;
  logic [R-1:0]  dout;
  logic          done, err, legal, tmo;
  always_comb begin
    legal   = &(bus.res_t ^ bus.res_f);
    tmo     = cnt == CW'(TIMEOUT - 1);
    state_n = state;
    case (state)
      IDLE:      state_n = (bus.start && ko_s) ? DATA_WAIT : IDLE;
      DATA_WAIT: state_n = !ko_s ? (legal ? NULL_WAIT : ERROR) : (tmo ? ERROR : DATA_WAIT);
      NULL_WAIT: state_n = ko_s ? IDLE : (tmo ? ERROR : NULL_WAIT);
      default:   state_n = ERROR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sync1  <= 1'b1;
      ko_s   <= 1'b1;
      cnt    <= '0;
      rail_t <= '0;
      rail_f <= '0;
      dout   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      sync1  <= bus.ko;
      ko_s   <= sync1;
      // counter restarts on every state change, so it only ever runs up to TIMEOUT-1
      cnt    <= (state_n != state) ? '0 : (state == DATA_WAIT || state == NULL_WAIT) ? cnt + 1'b1 : cnt;
      // rails carry DATA only while in DATA_WAIT; any exit goes straight to NULL
      rail_t <= (state_n == DATA_WAIT) ? ((state == IDLE) ? bus.din : rail_t) : '0;
      rail_f <= (state_n == DATA_WAIT) ? ((state == IDLE) ? ~bus.din : rail_f) : '0;
      dout   <= (state == DATA_WAIT && state_n == NULL_WAIT) ? bus.res_t : dout;
      done   <= state == NULL_WAIT && state_n == IDLE;
      err    <= err | (state_n == ERROR);
    end
  end
  assign bus.ready  = state == IDLE && ko_s;
  assign bus.rail_t = rail_t;
  assign bus.rail_f = rail_f;
  assign bus.dout   = dout;
  assign bus.done   = done;
  assign bus.err    = err;
endmodule
